// File: rtl/digit_entry_pkg.sv
// Shared types and BCD helpers for the digit entry controller.
package digit_entry_pkg;

  // Controller states: editing, one-cycle commit, one-cycle clear.
  typedef enum logic [1:0] {
    ST_EDIT   = 2'd0,
    ST_COMMIT = 2'd1,
    ST_CLEAR  = 2'd2
  } state_t;

  localparam logic [3:0] BCD_MAX = 4'd9;

  // Increment one BCD digit, 9 wraps to 0; a non-BCD nibble counts as 0.
  function automatic logic [3:0] bcd_inc(input logic [3:0] i_digit);
    logic [3:0] result;
    if (i_digit == BCD_MAX) begin
      result = 4'd0;
    end else if (i_digit > BCD_MAX) begin
      result = 4'd1;
    end else begin
      result = i_digit + 4'd1;
    end
    return result;
  endfunction

  // Decrement one BCD digit, 0 wraps to 9; a non-BCD nibble counts as 0.
  function automatic logic [3:0] bcd_dec(input logic [3:0] i_digit);
    logic [3:0] result;
    if ((i_digit == 4'd0) || (i_digit > BCD_MAX)) begin
      result = BCD_MAX;
    end else begin
      result = i_digit - 4'd1;
    end
    return result;
  endfunction

endpackage

// File: rtl/blink_timer.sv
// Cursor blink generator: toggles the blink level every BLINK_CLKS cycles.
// A restart pulse makes the cursor visible at once and restarts the half-period.
module blink_timer #(
  parameter int CLK_HZ   = 50_000_000,
  parameter int BLINK_MS = 250
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_restart,
  output logic o_blink
);

  localparam int BLINK_CLKS = (CLK_HZ / 1000) * BLINK_MS;
  localparam int CNT_W      = (BLINK_CLKS > 2) ? $clog2(BLINK_CLKS) : 1;
  localparam logic [CNT_W-1:0] TERM_COUNT = CNT_W'(BLINK_CLKS - 1);

  logic [CNT_W-1:0] r_count;
  logic             r_blink;
  logic             w_terminal;

  assign w_terminal = (r_count == TERM_COUNT);

  // Half-period counter with toggle at terminal count; restart wins.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
      r_blink <= 1'b1;
    end else if (i_restart) begin
      r_count <= '0;
      r_blink <= 1'b1;
    end else if (w_terminal) begin
      r_count <= '0;
      r_blink <= ~r_blink;
    end else begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_blink = r_blink;

endmodule

// File: rtl/digit_entry_ctrl.sv
// Multi-digit BCD entry controller: edits digits under a cursor from
// debounced button pulses and commits the value after the last digit.
module digit_entry_ctrl
  import digit_entry_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int NUM_DIGITS = 4,
  parameter int BLINK_MS   = 250
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_inc_p,
  input  logic                          i_dec_p,
  input  logic                          i_next_p,
  input  logic                          i_clr_p,
  output logic [4*NUM_DIGITS-1:0]       o_edit_bcd,
  output logic [$clog2(NUM_DIGITS)-1:0] o_cursor,
  output logic                          o_blink,
  output logic [4*NUM_DIGITS-1:0]       o_commit_bcd,
  output logic                          o_commit_valid
);

  localparam int CW = $clog2(NUM_DIGITS);
  localparam logic [CW-1:0] LAST_DIGIT = CW'(NUM_DIGITS - 1);

  state_t                  r_state;
  state_t                  w_state_next;
  logic [CW-1:0]           r_cursor;
  logic [CW-1:0]           w_cursor_next;
  logic [4*NUM_DIGITS-1:0] w_edit_bcd;
  logic [4*NUM_DIGITS-1:0] r_commit_bcd;
  logic                    r_commit_valid;
  logic                    w_inc_en;
  logic                    w_dec_en;
  logic                    w_clear_en;
  logic                    w_commit_load;
  logic                    w_restart;
  logic                    w_blink;

  // Next-state and event decode; only the highest-priority pulse is acted on.
  always_comb begin
    w_state_next  = r_state;
    w_cursor_next = r_cursor;
    w_inc_en      = 1'b0;
    w_dec_en      = 1'b0;
    w_clear_en    = 1'b0;
    w_commit_load = 1'b0;
    w_restart     = 1'b0;
    case (r_state)
      ST_EDIT: begin
        if (i_clr_p) begin
          w_state_next = ST_CLEAR;
          w_restart    = 1'b1;
        end else if (i_next_p) begin
          w_restart = 1'b1;
          if (r_cursor == '0) begin
            w_state_next  = ST_COMMIT;
            w_commit_load = 1'b1;
          end else begin
            w_cursor_next = r_cursor - CW'(1);
          end
        end else if (i_inc_p) begin
          w_inc_en  = 1'b1;
          w_restart = 1'b1;
        end else if (i_dec_p) begin
          w_dec_en  = 1'b1;
          w_restart = 1'b1;
        end
      end
      ST_COMMIT: begin
        w_cursor_next = LAST_DIGIT;
        w_state_next  = ST_EDIT;
      end
      ST_CLEAR: begin
        w_clear_en    = 1'b1;
        w_cursor_next = LAST_DIGIT;
        w_state_next  = ST_EDIT;
      end
      default: begin
        w_state_next = ST_EDIT;
      end
    endcase
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_EDIT;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Cursor register; starts on the leftmost digit.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cursor <= LAST_DIGIT;
    end else begin
      r_cursor <= w_cursor_next;
    end
  end

  // One register per digit; only the digit under the cursor steps.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      logic       w_sel;
      logic [3:0] r_digit;

      assign w_sel = (r_cursor == CW'(gi));

      // Digit update: clear, or inc/dec with BCD wrap when selected.
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          r_digit <= 4'd0;
        end else if (w_clear_en) begin
          r_digit <= 4'd0;
        end else if (w_inc_en && w_sel) begin
          r_digit <= bcd_inc(r_digit);
        end else if (w_dec_en && w_sel) begin
          r_digit <= bcd_dec(r_digit);
        end
      end

      assign w_edit_bcd[4*gi +: 4] = r_digit;
    end
  endgenerate

  // Commit register: loaded on the edge entering ST_COMMIT so the value and
  // its valid pulse appear together during the commit cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_commit_bcd   <= '0;
      r_commit_valid <= 1'b0;
    end else begin
      r_commit_valid <= w_commit_load;
      if (w_commit_load) begin
        r_commit_bcd <= w_edit_bcd;
      end
    end
  end

  blink_timer #(
    .CLK_HZ  (CLK_HZ),
    .BLINK_MS(BLINK_MS)
  ) u_blink_timer (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_restart(w_restart),
    .o_blink  (w_blink)
  );

  assign o_edit_bcd     = w_edit_bcd;
  assign o_cursor       = r_cursor;
  assign o_blink        = w_blink;
  assign o_commit_bcd   = r_commit_bcd;
  assign o_commit_valid = r_commit_valid;

endmodule

// File: tb/tb_digit_entry_ctrl.sv
// Self-checking bench for digit_entry_ctrl with a cycle-level reference model.
module tb_digit_entry_ctrl;

  localparam int ND = 4;
  localparam int BC = 4;  // blink half-period in clocks for CLK_HZ=1000, BLINK_MS=4

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        inc_p = 1'b0;
  logic        dec_p = 1'b0;
  logic        next_p = 1'b0;
  logic        clr_p = 1'b0;
  logic [15:0] edit_bcd;
  logic [1:0]  cursor;
  logic        blink;
  logic [15:0] commit_bcd;
  logic        commit_valid;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: digits as plain integers, value read as a decimal string.
  int m_dig[ND];
  int m_cur;
  int m_commit;
  bit m_valid;
  bit m_blink;
  int m_cnt;
  int m_busy;  // 0 = editing, 1 = commit cycle in progress, 2 = clear cycle in progress

  digit_entry_ctrl #(
    .CLK_HZ    (1000),
    .NUM_DIGITS(ND),
    .BLINK_MS  (4)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_inc_p       (inc_p),
    .i_dec_p       (dec_p),
    .i_next_p      (next_p),
    .i_clr_p       (clr_p),
    .o_edit_bcd    (edit_bcd),
    .o_cursor      (cursor),
    .o_blink       (blink),
    .o_commit_bcd  (commit_bcd),
    .o_commit_valid(commit_valid)
  );

  always #5 clk = ~clk;

  function automatic int m_value();
    int v = 0;
    for (int i = ND - 1; i >= 0; i--) v = v * 16 + m_dig[i];
    return v;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < ND; i++) m_dig[i] = 0;
    m_cur = ND - 1; m_commit = 0; m_valid = 0;
    m_blink = 1; m_cnt = 0; m_busy = 0;
  endfunction

  function automatic void model_edge(input bit inc, input bit dec, input bit nxt, input bit clr);
    bit accepted = 0;
    m_valid = 0;
    if (m_busy == 1) begin
      m_cur = ND - 1; m_busy = 0;
    end else if (m_busy == 2) begin
      for (int i = 0; i < ND; i++) m_dig[i] = 0;
      m_cur = ND - 1; m_busy = 0;
    end else begin
      accepted = inc | dec | nxt | clr;
      if (clr) m_busy = 2;
      else if (nxt) begin
        if (m_cur == 0) begin
          m_busy = 1; m_commit = m_value(); m_valid = 1;
        end else m_cur = m_cur - 1;
      end
      else if (inc) m_dig[m_cur] = (m_dig[m_cur] + 1) % 10;
      else if (dec) m_dig[m_cur] = (m_dig[m_cur] + 9) % 10;
    end
    if (accepted) begin
      m_cnt = 0; m_blink = 1;
    end else if (m_cnt == BC - 1) begin
      m_cnt = 0; m_blink = !m_blink;
    end else m_cnt++;
  endfunction

  // Drive one cycle of pulses, advance the model over the edge, release pulses.
  task automatic step(input bit inc, input bit dec, input bit nxt, input bit clr);
    inc_p = inc; dec_p = dec; next_p = nxt; clr_p = clr;
    @(posedge clk);
    model_edge(inc, dec, nxt, clr);
    #1;
    inc_p = 0; dec_p = 0; next_p = 0; clr_p = 0;
  endtask

  task automatic test_reset();
    rst_n = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    n_tests++; if (edit_bcd !== 16'h0000) begin n_fail++; $display("FAIL reset_edit: got %h expected 0000", edit_bcd); end
    n_tests++; if (cursor !== 2'd3) begin n_fail++; $display("FAIL reset_cursor: got %0d expected 3", cursor); end
    n_tests++; if (blink !== 1'b1) begin n_fail++; $display("FAIL reset_blink: got %b expected 1", blink); end
    n_tests++; if (commit_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", commit_valid); end
    n_tests++; if (commit_bcd !== 16'h0000) begin n_fail++; $display("FAIL reset_commit: got %h expected 0000", commit_bcd); end
    rst_n = 1;
    repeat (3) step(0, 0, 0, 0);
    n_tests++; if (edit_bcd !== 16'h0000) begin n_fail++; $display("FAIL idle_edit: got %h expected 0000", edit_bcd); end
    n_tests++; if (cursor !== 2'd3) begin n_fail++; $display("FAIL idle_cursor: got %0d expected 3", cursor); end
    n_tests++; if (commit_valid !== 1'b0) begin n_fail++; $display("FAIL idle_valid: got %b expected 0", commit_valid); end
    for (int c = 0; c < 8; c++) begin
      step(0, 0, 0, 0);
      n_tests++; if (blink !== m_blink) begin n_fail++; $display("FAIL idle_blink[%0d]: got %b expected %b", c, blink, m_blink); end
    end
    $display("[TB] reset/idle blink done");
  endtask

  task automatic test_dec_inc();
    repeat (2) step(0, 0, 0, 0);
    step(0, 1, 0, 0);
    n_tests++; if (edit_bcd !== 16'h9000) begin n_fail++; $display("FAIL dec_wrap: got %h expected 9000", edit_bcd); end
    n_tests++; if (blink !== 1'b1) begin n_fail++; $display("FAIL dec_blink: got %b expected 1", blink); end
    for (int k = 0; k < 2; k++) begin
      repeat (k + 4) step(0, 0, 0, 0);
      step(1, 0, 0, 0);
      n_tests++; if (blink !== 1'b1) begin n_fail++; $display("FAIL inc_blink[%0d]: got %b expected 1", k, blink); end
    end
    n_tests++; if (edit_bcd !== 16'h1000) begin n_fail++; $display("FAIL inc_wrap: got %h expected 1000", edit_bcd); end
    for (int c = 0; c < 6; c++) begin
      step(0, 0, 0, 0);
      n_tests++; if (blink !== m_blink) begin n_fail++; $display("FAIL post_inc_blink[%0d]: got %b expected %b", c, blink, m_blink); end
    end
    $display("[TB] dec/inc wrap: edit=%h", edit_bcd);
  endtask

  task automatic test_entry();
    step(0, 0, 0, 1);
    repeat (2) step(0, 0, 0, 0);
    for (int d = 1; d <= 4; d++) begin
      repeat (d) step(1, 0, 0, 0);
      step(0, 0, 1, 0);
      if (d < 4) begin
        n_tests++; if (commit_valid !== 1'b0) begin n_fail++; $display("FAIL early_valid[%0d]: got %b expected 0", d, commit_valid); end
      end
    end
    n_tests++; if (commit_valid !== 1'b1) begin n_fail++; $display("FAIL commit_valid: got %b expected 1", commit_valid); end
    n_tests++; if (commit_bcd !== 16'h1234) begin n_fail++; $display("FAIL commit_value: got %h expected 1234", commit_bcd); end
    step(0, 0, 0, 0);
    n_tests++; if (commit_valid !== 1'b0) begin n_fail++; $display("FAIL valid_one_cycle: got %b expected 0", commit_valid); end
    n_tests++; if (cursor !== 2'd3) begin n_fail++; $display("FAIL commit_cursor: got %0d expected 3", cursor); end
    n_tests++; if (edit_bcd !== 16'h1234) begin n_fail++; $display("FAIL commit_edit_kept: got %h expected 1234", edit_bcd); end
    $display("[TB] entry committed %h", commit_bcd);
  endtask

  task automatic test_priority();
    step(1, 0, 1, 0);
    n_tests++; if (cursor !== 2'd2) begin n_fail++; $display("FAIL prio_next_cursor: got %0d expected 2", cursor); end
    n_tests++; if (edit_bcd !== 16'h1234) begin n_fail++; $display("FAIL prio_next_digits: got %h expected 1234", edit_bcd); end
    step(1, 0, 0, 1);
    step(0, 0, 0, 0);
    n_tests++; if (edit_bcd !== 16'h0000) begin n_fail++; $display("FAIL prio_clr_edit: got %h expected 0000", edit_bcd); end
    n_tests++; if (cursor !== 2'd3) begin n_fail++; $display("FAIL prio_clr_cursor: got %0d expected 3", cursor); end
    n_tests++; if (commit_bcd !== 16'h1234) begin n_fail++; $display("FAIL prio_clr_commit: got %h expected 1234", commit_bcd); end
    $display("[TB] priority: edit=%h commit=%h", edit_bcd, commit_bcd);
  endtask

  task automatic test_commit_ignore();
    repeat (2) step(1, 0, 0, 0);
    repeat (3) step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    n_tests++; if (commit_valid !== 1'b1) begin n_fail++; $display("FAIL ign_valid: got %b expected 1", commit_valid); end
    step(1, 0, 0, 0);
    n_tests++; if (edit_bcd !== 16'h2000) begin n_fail++; $display("FAIL ign_inc_edit: got %h expected 2000", edit_bcd); end
    n_tests++; if (cursor !== 2'd3) begin n_fail++; $display("FAIL ign_cursor: got %0d expected 3", cursor); end
    step(0, 0, 0, 0);
    n_tests++; if (edit_bcd !== 16'h2000) begin n_fail++; $display("FAIL ign_edit_after: got %h expected 2000", edit_bcd); end
    n_tests++; if (commit_bcd !== 16'h2000) begin n_fail++; $display("FAIL ign_commit: got %h expected 2000", commit_bcd); end
    $display("[TB] inc during commit ignored: edit=%h", edit_bcd);
  endtask

  task automatic test_async_reset();
    step(0, 0, 0, 1);
    repeat (2) step(0, 0, 0, 0);
    repeat (5) step(1, 0, 0, 0);
    step(0, 0, 1, 0);
    repeat (6) step(1, 0, 0, 0);
    step(0, 0, 1, 0);
    n_tests++; if (edit_bcd !== 16'h5600) begin n_fail++; $display("FAIL pre_rst_edit: got %h expected 5600", edit_bcd); end
    n_tests++; if (cursor !== 2'd1) begin n_fail++; $display("FAIL pre_rst_cursor: got %0d expected 1", cursor); end
    #3 rst_n = 0;
    #1;
    model_reset();
    n_tests++; if (edit_bcd !== 16'h0000) begin n_fail++; $display("FAIL arst_edit: got %h expected 0000", edit_bcd); end
    n_tests++; if (cursor !== 2'd3) begin n_fail++; $display("FAIL arst_cursor: got %0d expected 3", cursor); end
    n_tests++; if (blink !== 1'b1) begin n_fail++; $display("FAIL arst_blink: got %b expected 1", blink); end
    n_tests++; if (commit_bcd !== 16'h0000) begin n_fail++; $display("FAIL arst_commit: got %h expected 0000", commit_bcd); end
    n_tests++; if (commit_valid !== 1'b0) begin n_fail++; $display("FAIL arst_valid: got %b expected 0", commit_valid); end
    repeat (2) @(posedge clk);
    #2 rst_n = 1;
    step(1, 0, 0, 0);
    n_tests++; if (edit_bcd !== 16'h1000) begin n_fail++; $display("FAIL resume_edit: got %h expected 1000", edit_bcd); end
    // Reset landing in the commit cycle kills the pulse.
    repeat (3) step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    n_tests++; if (commit_valid !== 1'b1) begin n_fail++; $display("FAIL pre_rst_valid: got %b expected 1", commit_valid); end
    #3 rst_n = 0;
    #1;
    model_reset();
    n_tests++; if (commit_valid !== 1'b0) begin n_fail++; $display("FAIL arst_commit_valid: got %b expected 0", commit_valid); end
    n_tests++; if (commit_bcd !== 16'h0000) begin n_fail++; $display("FAIL arst_commit_value: got %h expected 0000", commit_bcd); end
    repeat (2) @(posedge clk);
    #2 rst_n = 1;
    for (int c = 0; c < 3; c++) begin
      step(0, 0, 0, 0);
      n_tests++; if (commit_valid !== 1'b0) begin n_fail++; $display("FAIL post_rst_valid[%0d]: got %b expected 0", c, commit_valid); end
    end
    $display("[TB] async reset mid-entry and mid-commit done");
  endtask

  task automatic test_random();
    bit inc, dec, nxt, clr;
    int n_commits = 0;
    for (int t = 0; t < 400; t++) begin
      inc = ($urandom_range(0, 99) < 30);
      dec = ($urandom_range(0, 99) < 25);
      nxt = ($urandom_range(0, 99) < 20);
      clr = ($urandom_range(0, 99) < 4);
      if ($urandom_range(0, 9) < 3) begin inc = 0; dec = 0; nxt = 0; clr = 0; end
      step(inc, dec, nxt, clr);
      if (m_valid) n_commits++;
      n_tests++; if (edit_bcd !== 16'(m_value())) begin n_fail++; $display("FAIL rnd_edit[%0d]: got %h expected %h", t, edit_bcd, 16'(m_value())); end
      n_tests++; if (cursor !== 2'(m_cur)) begin n_fail++; $display("FAIL rnd_cursor[%0d]: got %0d expected %0d", t, cursor, m_cur); end
      n_tests++; if (blink !== m_blink) begin n_fail++; $display("FAIL rnd_blink[%0d]: got %b expected %b", t, blink, m_blink); end
      n_tests++; if (commit_valid !== m_valid) begin n_fail++; $display("FAIL rnd_valid[%0d]: got %b expected %b", t, commit_valid, m_valid); end
      n_tests++; if (commit_bcd !== 16'(m_commit)) begin n_fail++; $display("FAIL rnd_commit[%0d]: got %h expected %h", t, commit_bcd, 16'(m_commit)); end
    end
    $display("[TB] random: 400 cycles, %0d commits", n_commits);
  endtask

  initial begin
    model_reset();
    #2;
    test_reset();
    test_dec_inc();
    test_entry();
    test_priority();
    test_commit_ignore();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/digit_entry_ctrl.md
Name: digit_entry_ctrl

Overview:
- Consumes the one-cycle button pulses produced by the debouncer/one-shot stage (increment, decrement, next, clear).
- Maintains an editable multi-digit BCD value with a cursor, and supplies a cursor-blink strobe to the display driver.
- When the user steps past the last digit, the edit value is committed to the game logic with a one-cycle valid pulse.
- Sits between the per-button debouncers and the game/compare and seven-segment stages.

Parameters:
- CLK_HZ, 50_000_000: clock frequency in Hz.
- NUM_DIGITS, 4: number of BCD digits (legal range 2..8).
- BLINK_MS, 250: blink half-period in ms. BLINK_CLKS = (CLK_HZ/1000)*BLINK_MS, which must be ≥2.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  asynchronous reset, active-low.
- inc_p  in  1  one-cycle pulse: increment the digit under the cursor.
- dec_p  in  1  one-cycle pulse: decrement the digit under the cursor.
- next_p  in  1  one-cycle pulse: advance the cursor, or commit from the last digit.
- clr_p  in  1  one-cycle pulse: clear the edit value.
- edit_bcd  out  4*NUM_DIGITS  current edit digits. Digit i is bits [4i+3:4i]; digit 0 is rightmost.
- cursor  out  $clog2(NUM_DIGITS)  index of the digit being edited.
- blink  out  1  cursor-visible level.
- commit_bcd  out  4*NUM_DIGITS  last committed value.
- commit_valid  out  1  one-cycle pulse; commit_bcd is new in that same cycle.

Behaviour:
- Reset (rst_n low, asynchronous):
  - edit_bcd = 0, commit_bcd = 0.
  - cursor = NUM_DIGITS-1.
  - blink = 1, blink counter = 0.
  - commit_valid = 0, state = ST_EDIT.
- Reset mid-edit or mid-commit discards everything; no commit_valid is produced.
- All outputs are registered. A pulse sampled in cycle N takes effect at the edge closing cycle N and is visible in cycle N+1.
- States:
  - ST_EDIT: accepts events.
  - ST_COMMIT: lasts exactly one cycle.
  - ST_CLEAR: lasts exactly one cycle.
- Event priority in ST_EDIT when several pulses coincide: clr_p > next_p > inc_p > dec_p. Only the highest-priority event is acted on; the rest are dropped.
- inc_p: digit[cursor] += 1, with 9 wrapping to 0.
- dec_p: digit[cursor] -= 1, with 0 wrapping to 9. Other digits are untouched.
- Digit values are always in 0..9. Any non-BCD nibble, which is unreachable, is treated as 0 on the next inc or dec.
- next_p with cursor > 0: cursor -= 1.
- next_p with cursor == 0: go to ST_COMMIT.
- ST_COMMIT:
  - commit_bcd <= edit_bcd and commit_valid = 1 for this cycle only.
  - cursor <= NUM_DIGITS-1; edit_bcd is retained.
  - Returns to ST_EDIT.
- clr_p: go to ST_CLEAR.
- ST_CLEAR:
  - edit_bcd <= 0, cursor <= NUM_DIGITS-1; commit_bcd is unchanged.
  - Returns to ST_EDIT.
- Pulses arriving while in ST_COMMIT or ST_CLEAR are ignored. Debounced pulses are ≥1 ms apart, so none are lost in practice.
- Blink timer:
  - Counts 0..BLINK_CLKS-1. At terminal count it toggles blink and wraps to 0.
  - Any accepted event (inc, dec, next, clr) forces blink = 1 and counter = 0 on the same edge, so the cursor is visible right after an edit.
- Illegal state encoding → ST_EDIT. Data registers are unchanged in that case.

Decomposition:
- Package digit_entry_pkg holds:
  - typedef enum logic [1:0] state_t {ST_EDIT, ST_COMMIT, ST_CLEAR}.
  - localparam BCD_MAX = 4'd9.
  - Functions bcd_inc and bcd_dec (nibble in, nibble out, with wrap).
- One sub-module: blink_timer.
  - Parameters: CLK_HZ, BLINK_MS.
  - Ports: clk, rst_n, restart, blink.
  - Owns the counter and the toggle.
- Top-level digit_entry_ctrl holds the FSM, the digit registers, the cursor and the commit register.

Test Plan (NUM_DIGITS=4, CLK_HZ=1000, BLINK_MS=4 → BLINK_CLKS=4):
- Release rst_n, then wait 3 cycles → edit_bcd=16'h0000, cursor=3, commit_valid=0. Then idle 8 cycles → blink toggles every 4 cycles.
- Pulse dec_p once → edit_bcd=16'h9000. Then inc_p twice → 16'h1000. Blink is forced to 1 with the counter restarted on each pulse.
- Enter 1,2,3,4 (inc×1, next, inc×2, next, inc×3, next, inc×4, next):
  - The final next yields commit_valid=1 for exactly one cycle with commit_bcd=16'h1234.
  - cursor returns to 3; edit_bcd stays 16'h1234.
- With edit_bcd=16'h1234: assert inc_p and next_p in the same cycle → only next is applied (cursor decrements, digits unchanged). clr_p+inc_p together → edit_bcd=16'h0000, commit_bcd still 16'h1234.
- Drop rst_n asynchronously mid-entry (edit 16'h5600, cursor=1) → all outputs return to reset values immediately with no commit_valid pulse. Editing resumes normally after release.
- Drive inc_p in the ST_COMMIT cycle → ignored. The digit is unchanged on return to ST_EDIT.
